// File: rtl/display_scan_arbiter.sv
// display_scan_arbiter
//   Picks one of N_SRC seven-segment sources by one-hot select and scans it out
//   onto the shared digit-enable / segment pins. A new source takes effect only
//   at a frame boundary, and one blank frame is inserted between sources, so no
//   digit ever shows a mix of two sources. The block also flags invalid selects
//   and can blink the display on a frame basis.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   sel         one-hot source select
//   seg_bus     source s, digit d at [(s*NUM_DIGITS+d)*SEG_W +: SEG_W], active-low
//   blink_en    blink the displayed source
//   AN          digit enables, active-low, registered
//   led         segment drive, active-low, registered
//   active_src  index of the committed source, registered
//   sel_err     sel on the previous cycle was zero or multi-hot
//
// Blink phase states
//   state  | meaning
//   PH_ON  | segments follow the committed source
//   PH_OFF | segments forced off while blink_en is high
module display_scan_arbiter #(
  parameter int N_SRC        = 15,
  parameter int NUM_DIGITS   = 8,
  parameter int SEG_W        = 7,
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64,
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_SRC-1:0]                  sel,
  input  logic [N_SRC*NUM_DIGITS*SEG_W-1:0] seg_bus,
  input  logic                              blink_en,
  output logic [NUM_DIGITS-1:0]             AN,
  output logic [SEG_W-1:0]                  led,
  output logic [SRC_W-1:0]                  active_src,
  output logic                              sel_err
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic {
    PH_ON  = 1'b0,
    PH_OFF = 1'b1
  } phase_e;

  logic [DIV_W-1:0]      div_cnt_q;
  logic [DIG_W-1:0]      dig_q;
  logic [SRC_W-1:0]      pend_q;
  logic [SRC_W-1:0]      active_src_q;
  logic                  blank_q;
  phase_e                phase_q;
  logic [FC_W-1:0]       frame_cnt_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic [SEG_W-1:0]      led_q;
  logic                  sel_err_q;

  logic                  tc;
  logic                  frame_end;
  logic                  sel_onehot;
  logic [SRC_W-1:0]      sel_idx;
  int unsigned           seg_base;
  logic [SEG_W-1:0]      cur_seg;
  logic                  blanked;
  logic [NUM_DIGITS-1:0] an_d;
  logic [SEG_W-1:0]      led_d;

  always_comb begin
    tc         = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
    frame_end  = tc && (dig_q == DIG_W'(NUM_DIGITS - 1));
    sel_onehot = (sel != '0) && ((sel & (sel - N_SRC'(1))) == '0);
    sel_idx    = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (sel[i]) sel_idx = SRC_W'(i);
    end
    // Source data is read live; a change on seg_bus shows at the next register update.
    seg_base = (int'(active_src_q) * NUM_DIGITS + int'(dig_q)) * SEG_W;
    cur_seg  = SEG_W'(seg_bus >> seg_base);
    blanked  = blank_q || (blink_en && (phase_q == PH_OFF));
    led_d    = blanked ? '1 : cur_seg;
    an_d     = ~(NUM_DIGITS'(1) << dig_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      dig_q        <= '0;
      pend_q       <= '0;
      active_src_q <= '0;
      blank_q      <= 1'b1;
      phase_q      <= PH_ON;
      frame_cnt_q  <= '0;
      an_q         <= '1;
      led_q        <= '1;
      sel_err_q    <= 1'b0;
    end else begin
      div_cnt_q <= tc ? '0 : div_cnt_q + DIV_W'(1);
      if (tc) begin
        dig_q <= (dig_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : dig_q + DIG_W'(1);
      end

      an_q  <= an_d;
      led_q <= led_d;

      // An invalid select keeps the last good pending source.
      sel_err_q <= ~sel_onehot;
      if (sel_onehot) pend_q <= sel_idx;

      // Commit uses the pending value from before this edge, so a select that
      // arrives on the frame_end cycle waits for the next frame boundary.
      if (frame_end) begin
        active_src_q <= pend_q;
        blank_q      <= (pend_q != active_src_q);
      end

      if (!blink_en) begin
        frame_cnt_q <= '0;
        phase_q     <= PH_ON;
      end else if (frame_end) begin
        if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
          frame_cnt_q <= '0;
          phase_q     <= (phase_q == PH_ON) ? PH_OFF : PH_ON;
        end else begin
          frame_cnt_q <= frame_cnt_q + FC_W'(1);
        end
      end
    end
  end

  assign AN         = an_q;
  assign led        = led_q;
  assign active_src = active_src_q;
  assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_display_scan_arbiter.sv
// Bench for display_scan_arbiter with N_SRC=4, NUM_DIGITS=8, SCAN_DIV=4,
// BLINK_FRAMES=2. Source s digit d carries the pattern {s[2:0], d[3:0]}.
// Expected values are tagged with the clock edge after which they must hold
// and a negedge monitor compares them when that edge has been reached.
module tb_display_scan_arbiter;

  localparam int NS = 4;
  localparam int ND = 8;
  localparam int SW = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS-1:0]     sel;
  logic [NS*ND*SW-1:0] seg_bus;
  logic              blink_en;
  logic [ND-1:0]     AN;
  logic [SW-1:0]     led;
  logic [1:0]        active_src;
  logic              sel_err;

  display_scan_arbiter #(
    .N_SRC(NS), .NUM_DIGITS(ND), .SEG_W(SW), .SCAN_DIV(4), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .seg_bus(seg_bus), .blink_en(blink_en),
    .AN(AN), .led(led), .active_src(active_src), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int        cyc;
    string     nm;
    bit        c_an;
    logic [7:0] an;
    bit        c_led;
    logic [6:0] led;
    bit        c_src;
    logic [1:0] src;
    bit        c_err;
    logic      err;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [6:0] pat(input int s, input int d);
    return 7'((s << 4) | d);
  endfunction

  function automatic logic [7:0] an_of(input int d);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << d);
  endfunction

  task automatic push(input int c, input string nm, input bit ca, input logic [7:0] an,
                      input bit cl, input logic [6:0] l, input bit cs, input logic [1:0] s,
                      input bit ce, input logic e);
    exp_t x;
    x.cyc = c; x.nm = nm;
    x.c_an = ca; x.an = an; x.c_led = cl; x.led = l;
    x.c_src = cs; x.src = s; x.c_err = ce; x.err = e;
    sb.push_back(x);
  endtask

  task automatic exp_dl(input int c, input string nm, input logic [7:0] an, input logic [6:0] l);
    push(c, nm, 1'b1, an, 1'b1, l, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic exp_src(input int c, input string nm, input int s);
    push(c, nm, 1'b0, 8'h00, 1'b0, 7'h00, 1'b1, 2'(s), 1'b0, 1'b0);
  endtask

  task automatic exp_err(input int c, input string nm, input logic e);
    push(c, nm, 1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 2'd0, 1'b1, e);
  endtask

  task automatic exp_rst(input int c, input string nm);
    push(c, nm, 1'b1, 8'hFF, 1'b1, 7'h7F, 1'b1, 2'd0, 1'b1, 1'b0);
  endtask

  task automatic check_entry(input exp_t e);
    if (e.c_an) begin
      n_chk++;
      if (AN === e.an) n_pass++;
      else $display("FAIL %s AN @cyc %0d: got %h want %h", e.nm, e.cyc, AN, e.an);
    end
    if (e.c_led) begin
      n_chk++;
      if (led === e.led) n_pass++;
      else $display("FAIL %s led @cyc %0d: got %h want %h", e.nm, e.cyc, led, e.led);
    end
    if (e.c_src) begin
      n_chk++;
      if (active_src === e.src) n_pass++;
      else $display("FAIL %s active_src @cyc %0d: got %0d want %0d", e.nm, e.cyc, active_src, e.src);
    end
    if (e.c_err) begin
      n_chk++;
      if (sel_err === e.err) n_pass++;
      else $display("FAIL %s sel_err @cyc %0d: got %b want %b", e.nm, e.cyc, sel_err, e.err);
    end
  endtask

  // Monitor: compare every expectation whose edge has just been reached.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check_entry(sb[i]);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_chk++;
        $display("FAIL %s stale @cyc %0d: expectation never compared, now cyc %0d", sb[i].nm, sb[i].cyc, cyc);
        sb.delete(i);
      end
    end
  end

  task automatic goto(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(output int r);
    rst = 1'b1;
    @(posedge clk);
    #1;
    r = cyc;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, r2, r3;
    for (int s = 0; s < NS; s++)
      for (int d = 0; d < ND; d++)
        seg_bus[(s*ND+d)*SW +: SW] = pat(s, d);
    rst      = 1'b1;
    sel      = 4'b0001;
    blink_en = 1'b0;

    // Reset, scan walk, blank first frame, then source 0.
    do_reset(r);
    exp_rst(r, "reset");
    for (int d = 0; d < ND; d++) begin
      exp_dl(r + 4*d + 1, "walk_first", an_of(d), 7'h7F);
      exp_dl(r + 4*d + 4, "walk_last",  an_of(d), 7'h7F);
      exp_dl(r + 32 + 4*d + 2, "frame1_src0", an_of(d), pat(0, d));
    end
    exp_src(r + 40, "src0", 0);

    // Mid-frame switch to source 2.
    exp_dl(r + 62, "old_src_finish", an_of(7), pat(0, 7));
    exp_src(r + 63, "pre_commit", 0);
    exp_src(r + 64, "commit2", 2);
    exp_dl(r + 66, "switch_blank_d0", an_of(0), 7'h7F);
    exp_dl(r + 90, "switch_blank_d6", an_of(6), 7'h7F);
    exp_dl(r + 98, "src2_d0", an_of(0), pat(2, 0));
    exp_dl(r + 127, "src2_d7", an_of(7), pat(2, 7));

    // Multi-hot select for three cycles.
    exp_err(r + 100, "err_before", 1'b0);
    exp_err(r + 101, "err_1", 1'b1);
    exp_err(r + 102, "err_2", 1'b1);
    exp_err(r + 103, "err_3", 1'b1);
    exp_err(r + 104, "err_after", 1'b0);
    exp_dl(r + 130, "no_blank_after_err", an_of(0), pat(2, 0));
    exp_src(r + 130, "src_hold_err", 2);

    // Select change landing on the frame_end cycle.
    exp_src(r + 160, "fe_not_committed", 2);
    exp_dl(r + 162, "fe_still_src2", an_of(0), pat(2, 0));
    exp_src(r + 191, "fe_src_held", 2);
    exp_src(r + 192, "fe_commit3", 3);
    exp_dl(r + 194, "fe_blank", an_of(0), 7'h7F);
    exp_dl(r + 226, "src3_d0", an_of(0), pat(3, 0));
    exp_dl(r + 250, "src3_d6", an_of(6), pat(3, 6));

    goto(r + 40);  sel = 4'b0100;
    goto(r + 100); sel = 4'b0110;
    goto(r + 103); sel = 4'b0100;
    goto(r + 159); sel = 4'b1000;
    goto(r + 260); sel = 4'b0001;

    // Blink: 2 frames visible, 2 frames dark.
    do_reset(r2);
    blink_en = 1'b1;
    exp_rst(r2, "reset2");
    exp_dl(r2 + 34,  "blink_on_f1",  an_of(0), pat(0, 0));
    exp_dl(r2 + 70,  "blink_off_f2", an_of(1), 7'h7F);
    exp_dl(r2 + 120, "blink_off_f3", an_of(5), 7'h7F);
    exp_dl(r2 + 140, "blink_on_f4",  an_of(2), pat(0, 2));
    exp_dl(r2 + 180, "blink_on_f5",  an_of(4), pat(0, 4));
    exp_dl(r2 + 200, "blink_off_f6", an_of(1), 7'h7F);
    exp_dl(r2 + 205, "blink_off_pre_drop", an_of(3), 7'h7F);
    exp_dl(r2 + 209, "blink_drop_vis", an_of(4), pat(0, 4));
    exp_dl(r2 + 212, "blink_drop_vis2", an_of(4), pat(0, 4));
    exp_dl(r2 + 230, "blink_dis_f7", an_of(1), pat(0, 1));
    exp_src(r2 + 256, "commit2_b", 2);
    exp_err(r2 + 261, "err_b0", 1'b0);
    exp_err(r2 + 262, "err_b1", 1'b1);

    goto(r2 + 205); blink_en = 1'b0;
    goto(r2 + 240); sel = 4'b0100;
    goto(r2 + 261); sel = 4'b0011;
    goto(r2 + 262);

    // Mid-digit reset with a multi-hot select present.
    do_reset(r3);
    sel = 4'b0010;
    exp_rst(r3, "reset_mid");
    exp_err(r3 + 1, "err_after_rst", 1'b0);
    exp_dl(r3 + 3,  "rst_d0_blank", an_of(0), 7'h7F);
    exp_dl(r3 + 5,  "rst_d1_blank", an_of(1), 7'h7F);
    exp_src(r3 + 31, "rst_src0", 0);
    exp_src(r3 + 32, "rst_commit1", 1);
    exp_dl(r3 + 34, "rst_f1_blank", an_of(0), 7'h7F);
    exp_dl(r3 + 66, "src1_d0", an_of(0), pat(1, 0));
    exp_dl(r3 + 75, "src1_d2", an_of(2), pat(1, 2));

    goto(r3 + 80);
    @(negedge clk);
    #1;
    foreach (sb[i]) begin
      n_chk++;
      $display("FAIL %s pending @cyc %0d: expectation never compared", sb[i].nm, sb[i].cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
